stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
//============================================================================
// Module      : stopwatch_ctrl
// Description : Four-digit BCD stopwatch controller with run/pause/lap
//               modes, a lap-freeze display register and a sticky
//               overflow flag.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   CK        in   1   clock, rising edge active
//   Clear     in   1   asynchronous active-high reset
//   Tick      in   1   time-base pulse; counts while in RUN or LAP
//   StartStop in   1   command pulse: start / stop
//   LapReset  in   1   command pulse: lap / resume / reset (from PAUSE)
//   Digits    out  16  live count, packed BCD {d3,d2,d1,d0}
//   Display   out  16  shown value, frozen while in LAP
//   State     out  2   IDLE=00, RUN=01, PAUSE=10, LAP=11
//   Ovf       out  1   sticky overflow flag
// Parameters
//   WRAP      1 = wrap 9999->0000, 0 = saturate at 9999
//============================================================================
module stopwatch_ctrl #(
    parameter int unsigned WRAP = 1
) (
    input  logic        CK,
    input  logic        Clear,
    input  logic        Tick,
    input  logic        StartStop,
    input  logic        LapReset,
    output logic [15:0] Digits,
    output logic [15:0] Display,
    output logic [1:0]  State,
    output logic        Ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_display;
    logic        r_ovf;

    state_t      w_next_state;
    logic        w_count_en;
    logic [3:0]  w_max;        // digit i currently holds 9
    logic [3:0]  w_inc;        // digit i advances this cycle (all lower digits are 9)
    logic [15:0] w_incd;       // count + 1 in BCD, wrapping 9999 -> 0000
    logic        w_all_nines;
    logic [15:0] w_next_count;
    logic        w_ovf_hit;
    logic        w_to_idle;

    // Counting depends only on the pre-edge state, so a tick arriving with a
    // command is counted exactly when the machine was already RUN or LAP.
    assign w_count_en = Tick && ((r_state == S_RUN) || (r_state == S_LAP));

    // Single-edge BCD increment: each digit sees its carry-in combinationally
    // from the lower digits, so all digits update on the same clock edge.
    assign w_inc = {&w_max[2:0], &w_max[1:0], w_max[0], 1'b1};

    for (genvar i = 0; i < 4; i++) begin : g_digit
        assign w_max[i] = (r_count[i*4 +: 4] == 4'd9);
        assign w_incd[i*4 +: 4] = !w_inc[i] ? r_count[i*4 +: 4] :
                                  (w_max[i] ? 4'd0 : r_count[i*4 +: 4] + 4'd1);
    end

    assign w_all_nines = &w_max;
    assign w_ovf_hit   = w_count_en && w_all_nines;

    always_comb begin
        w_next_count = r_count;
        if (w_count_en) begin
            if (w_all_nines && (WRAP == 0)) begin
                w_next_count = r_count;
            end else begin
                w_next_count = w_incd;
            end
        end
    end

    // StartStop is tested first everywhere, giving it priority over LapReset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (StartStop) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (StartStop)     w_next_state = S_PAUSE;
                else if (LapReset) w_next_state = S_LAP;
            end
            S_LAP: begin
                if (StartStop)     w_next_state = S_PAUSE;
                else if (LapReset) w_next_state = S_RUN;
            end
            S_PAUSE: begin
                if (StartStop)     w_next_state = S_RUN;
                else if (LapReset) w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_to_idle = (r_state == S_PAUSE) && (w_next_state == S_IDLE);

    always_ff @(posedge CK or posedge Clear) begin
        if (Clear) begin
            r_state   <= S_IDLE;
            r_count   <= 16'h0000;
            r_display <= 16'h0000;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_to_idle) begin
                r_count   <= 16'h0000;
                r_display <= 16'h0000;
                r_ovf     <= 1'b0;
            end else begin
                r_count <= w_next_count;
                r_ovf   <= r_ovf | w_ovf_hit;
                // Display freezes on the post-edge value of the LAP entry edge
                // and otherwise follows the post-edge count.
                if ((w_next_state != S_LAP) || (r_state != S_LAP)) begin
                    r_display <= w_next_count;
                end
            end
        end
    end

    assign Digits  = r_count;
    assign Display = r_display;
    assign State   = r_state;
    assign Ovf     = r_ovf;

endmodule
`default_nettype wire
